tft_rx_capture: RTL and testbench

- Receive-side counterpart of the panel timing generator: samples an RGB565 parallel video bus (hsync, vsync, de, rgb) in the pixel clock domain.
- Recovers pixel coordinates and emits a framed pixel stream (valid, sof, eol, x, y, data).
- Measures each frame's active width and height, checks them against the expected 480x272 geometry, and reports lock and per-frame errors.
- Used for loopback verification of the TFT output path and as the front end of any future video-input pipeline.

---
 rtl/tft_pkg.sv | 28 ++
 rtl/tft_rx_capture_if.sv | 37 +++
 rtl/tft_edge_det.sv | 28 ++
 rtl/tft_rx_capture.sv | 215 +++++++++++++++++++++
 tb/tb_tft_rx_capture.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tft_pkg.sv
// Constants and types shared between the TFT timing generator and the receive capture path.
package tft_pkg;

  localparam int TFT_H_ACTIVE = 480;
  localparam int TFT_V_ACTIVE = 272;
  localparam int PIX_W        = 16;
  localparam int COORD_W      = 10;

  typedef logic [PIX_W-1:0]   pix_t;
  typedef logic [COORD_W-1:0] coord_t;

  // RGB565 field layout: red in [15:11], green in [10:5], blue in [4:0].
  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef enum logic {
    SEEK  = 1'b0,
    FRAME = 1'b1
  } rx_state_t;

  function automatic coord_t sat_inc(input coord_t v);
    return (v == '1) ? v : v + coord_t'(1);
  endfunction

endpackage

// File: rtl/tft_rx_capture_if.sv
// Video input bus plus the framed pixel stream and frame status produced by the capture block.
interface tft_rx_capture_if;
  import tft_pkg::*;

  logic        vid_vsync;
  logic        vid_hsync;
  logic        vid_de;
  pix_t        vid_rgb;

  logic        pix_valid;
  pix_t        pix_data;
  coord_t      pix_x;
  coord_t      pix_y;
  logic        pix_sof;
  logic        pix_eol;

  coord_t      meas_width;
  coord_t      meas_height;
  logic        frame_done;
  logic        err_hlen;
  logic        err_vlen;
  logic        locked;
  logic [15:0] frame_cnt;

  modport master (
    output vid_vsync, vid_hsync, vid_de, vid_rgb,
    input  pix_valid, pix_data, pix_x, pix_y, pix_sof, pix_eol,
    input  meas_width, meas_height, frame_done, err_hlen, err_vlen, locked, frame_cnt
  );

  modport slave (
    input  vid_vsync, vid_hsync, vid_de, vid_rgb,
    output pix_valid, pix_data, pix_x, pix_y, pix_sof, pix_eol,
    output meas_width, meas_height, frame_done, err_hlen, err_vlen, locked, frame_cnt
  );

endinterface

// File: rtl/tft_edge_det.sv
// Registered input with a one-flop history; rise/fall pulse for one cycle on each transition.
module tft_edge_det
  import tft_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic q_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      q      <= 1'b0;
      q_prev <= 1'b0;
    end else begin
      q      <= d;
      q_prev <= q;
    end
  end

  assign rise = q & ~q_prev;
  assign fall = ~q & q_prev;

endmodule

// File: rtl/tft_rx_capture.sv
// DE-framed RGB565 capture: recovers x/y, emits a framed pixel stream, measures geometry, tracks lock.
module tft_rx_capture
  import tft_pkg::*;
#(
  parameter int   H_ACTIVE    = TFT_H_ACTIVE,
  parameter int   V_ACTIVE    = TFT_V_ACTIVE,
  parameter logic VS_POL      = 1'b0,
  parameter int   LOCK_FRAMES = 2
) (
  input logic             sys_clk,
  input logic             sys_rst,
  tft_rx_capture_if.slave bus
);

  localparam coord_t     H_C    = coord_t'(H_ACTIVE);
  localparam coord_t     V_C    = coord_t'(V_ACTIVE);
  localparam coord_t     EOL_X  = coord_t'(H_ACTIVE - 1);
  localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

  localparam int NSIG   = 2;
  localparam int SIG_VS = 0;
  localparam int SIG_DE = 1;

  // ---- input stage ----
  logic [NSIG-1:0] sig_in, sig_lvl, sig_rise, sig_fall;

  assign sig_in = {bus.vid_de, (bus.vid_vsync == VS_POL)};

  for (genvar i = 0; i < NSIG; i++) begin : g_edge
    tft_edge_det u_edge (
      .clk  (sys_clk),
      .rst  (sys_rst),
      .d    (sig_in[i]),
      .q    (sig_lvl[i]),
      .rise (sig_rise[i]),
      .fall (sig_fall[i])
    );
  end

  rgb565_t rgb_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) rgb_q <= '0;
    else         rgb_q <= rgb565_t'(bus.vid_rgb);
  end

  logic de_q, de_fall, vs_start;
  assign de_q     = sig_lvl[SIG_DE];
  assign de_fall  = sig_fall[SIG_DE];
  assign vs_start = sig_rise[SIG_VS];

  // Framing is DE based; hsync and the vsync level/trailing edge carry no information here.
  logic unused_sigs;
  assign unused_sigs = &{1'b0, bus.vid_hsync, sig_lvl[SIG_VS], sig_fall[SIG_VS], sig_rise[SIG_DE]};

  // ---- FSM ----
  rx_state_t state, state_nx;
  logic      frame_start, frame_close;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= SEEK;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    frame_start = 1'b0;
    frame_close = 1'b0;
    case (state)
      SEEK: begin
        if (vs_start) begin
          state_nx    = FRAME;
          frame_start = 1'b1;
        end
      end
      FRAME: begin
        if (vs_start) begin
          frame_start = 1'b1;
          frame_close = 1'b1;
        end
      end
      default: state_nx = SEEK;
    endcase
  end

  // ---- counters and frame-close arithmetic ----
  coord_t x, y, line_len, line_cnt, last_len;
  logic   hlen_flag;
  logic   [3:0] good_cnt;

  logic   in_frame, line_open, hlen_close, vlen_close, good_close;
  logic   pix_take, pix_ok;
  coord_t cnt_close, w_close, x_cur, y_cur;
  logic   [3:0] good_nx;

  assign in_frame = (state == FRAME);

  // A line still open at vs_start is closed in the same cycle, ahead of the frame close.
  assign line_open  = frame_close && (line_len != '0);
  assign cnt_close  = line_open ? sat_inc(line_cnt) : line_cnt;
  assign w_close    = line_open ? line_len : last_len;
  assign hlen_close = hlen_flag | (line_open && (line_len != H_C));
  assign vlen_close = (cnt_close != V_C);
  assign good_close = !hlen_close && !vlen_close;
  assign good_nx    = (good_cnt >= LOCK_N) ? good_cnt : good_cnt + 4'd1;

  // The pixel under vs_start already belongs to the new frame, so it is (0,0).
  assign pix_take = de_q && (in_frame || frame_start);
  assign x_cur    = frame_start ? '0 : x;
  assign y_cur    = frame_start ? '0 : y;
  assign pix_ok   = pix_take && (x_cur < H_C) && (y_cur < V_C);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      x         <= '0;
      y         <= '0;
      line_len  <= '0;
      line_cnt  <= '0;
      last_len  <= '0;
      hlen_flag <= 1'b0;
    end else if (frame_start) begin
      x         <= pix_take ? coord_t'(1) : '0;
      line_len  <= pix_take ? coord_t'(1) : '0;
      y         <= '0;
      line_cnt  <= '0;
      last_len  <= '0;
      hlen_flag <= 1'b0;
    end else if (in_frame) begin
      if (de_q) begin
        x        <= sat_inc(x);
        line_len <= sat_inc(line_len);
      end else if (de_fall) begin
        if (line_len != H_C) hlen_flag <= 1'b1;
        line_cnt <= sat_inc(line_cnt);
        y        <= sat_inc(line_cnt);
        x        <= '0;
        line_len <= '0;
        last_len <= line_len;
      end
    end
  end

  // ---- measurement, status and lock ----
  coord_t      meas_width, meas_height;
  logic        frame_done, err_hlen, err_vlen, locked;
  logic [15:0] frame_cnt;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      meas_width  <= '0;
      meas_height <= '0;
      frame_done  <= 1'b0;
      err_hlen    <= 1'b0;
      err_vlen    <= 1'b0;
      locked      <= 1'b0;
      frame_cnt   <= '0;
      good_cnt    <= '0;
    end else begin
      frame_done <= 1'b0;
      if (frame_close) begin
        meas_width  <= w_close;
        meas_height <= cnt_close;
        err_hlen    <= hlen_close;
        err_vlen    <= vlen_close;
        frame_done  <= 1'b1;
        frame_cnt   <= frame_cnt + 16'd1;
        if (good_close) begin
          good_cnt <= good_nx;
          locked   <= (good_nx >= LOCK_N);
        end else begin
          good_cnt <= '0;
          locked   <= 1'b0;
        end
      end
    end
  end

  // ---- pixel output register ----
  logic   pix_valid, pix_sof, pix_eol;
  pix_t   pix_data;
  coord_t pix_x, pix_y;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pix_valid <= 1'b0;
      pix_data  <= '0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_sof   <= 1'b0;
      pix_eol   <= 1'b0;
    end else begin
      pix_valid <= pix_ok;
      pix_data  <= pix_t'(rgb_q);
      pix_x     <= x_cur;
      pix_y     <= y_cur;
      pix_sof   <= pix_ok && (x_cur == '0) && (y_cur == '0);
      pix_eol   <= pix_ok && (x_cur == EOL_X);
    end
  end

  assign bus.pix_valid   = pix_valid;
  assign bus.pix_data    = pix_data;
  assign bus.pix_x       = pix_x;
  assign bus.pix_y       = pix_y;
  assign bus.pix_sof     = pix_sof;
  assign bus.pix_eol     = pix_eol;
  assign bus.meas_width  = meas_width;
  assign bus.meas_height = meas_height;
  assign bus.frame_done  = frame_done;
  assign bus.err_hlen    = err_hlen;
  assign bus.err_vlen    = err_vlen;
  assign bus.locked      = locked;
  assign bus.frame_cnt   = frame_cnt;

endmodule

// File: tb/tb_tft_rx_capture.sv
// Bench for tft_rx_capture on a reduced 16x6 geometry; frame table plus reset and coincident-sync sequences.
module tb_tft_rx_capture;
  import tft_pkg::*;

  localparam int H = 16;
  localparam int V = 6;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  always #5 sys_clk = ~sys_clk;

  tft_rx_capture_if bus();

  tft_rx_capture #(
    .H_ACTIVE    (H),
    .V_ACTIVE    (V),
    .VS_POL      (1'b0),
    .LOCK_FRAMES (2)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  typedef struct {
    logic [15:0] d;
    int          x;
    int          y;
    bit          sof;
    bit          eol;
  } exp_pix_t;

  typedef struct {
    int nlines; int sidx; int slen;
    int w; int h; bit eh; bit ev; bit lk; int nv; int neol;
  } vec_t;

  exp_pix_t    exp_q[$];
  exp_pix_t    mon_e;
  int          n_tests = 0, n_fail = 0;
  int          fd_cnt = 0, fd_exp = 0, tot_v = 0, sb_bad = 0;
  int          vcnt = 0, sofc = 0, eolc = 0, snap_v = 0, snap_sof = 0, snap_eol = 0;
  bit          cap = 0;
  logic [15:0] seed = 16'h0000;
  vec_t        vec[10];
  vec_t        nom_unlk, nom_lk;

  // Monitor: per-frame counts snapshotted at frame_done, scoreboard on every valid pixel.
  always @(negedge sys_clk) begin
    if (bus.frame_done) begin
      fd_cnt++;
      snap_v = vcnt; snap_sof = sofc; snap_eol = eolc;
      vcnt = 0; sofc = 0; eolc = 0;
    end
    if (bus.pix_valid) begin
      tot_v++; vcnt++;
      if (bus.pix_sof) sofc++;
      if (bus.pix_eol) eolc++;
      if (exp_q.size() == 0) sb_bad++;
      else begin
        mon_e = exp_q.pop_front();
        if (bus.pix_data !== mon_e.d || int'(bus.pix_x) != mon_e.x || int'(bus.pix_y) != mon_e.y ||
            bus.pix_sof !== mon_e.sof || bus.pix_eol !== mon_e.eol) sb_bad++;
      end
    end
    if (sys_rst) begin
      exp_q.delete();
      vcnt = 0; sofc = 0; eolc = 0;
    end
  end

  task automatic tick();
    @(posedge sys_clk); #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] pat(input int l, input int c);
    return 16'((l << 10) | c) ^ seed;
  endfunction

  task automatic drive_pix(input int l, input int c);
    bus.vid_de  = 1'b1;
    bus.vid_rgb = pat(l, c);
    if (cap && c < H && l < V)
      exp_q.push_back('{d: pat(l, c), x: c, y: l, sof: (l == 0 && c == 0), eol: (c == H - 1)});
  endtask

  task automatic send_line(input int l, input int len);
    for (int c = 0; c < len; c++) begin
      drive_pix(l, c);
      tick();
    end
    bus.vid_de  = 1'b0;
    bus.vid_rgb = '0;
    bus.vid_hsync = 1'b1;
    repeat (4) tick();
    bus.vid_hsync = 1'b0;
  endtask

  task automatic send_frame(input vec_t v);
    for (int l = 0; l < v.nlines; l++) send_line(l, (l == v.sidx) ? v.slen : H);
  endtask

  task automatic vs_pulse();
    bus.vid_vsync = 1'b0;
    repeat (2) tick();
    bus.vid_vsync = 1'b1;
    repeat (2) tick();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " pix_valid"}, int'(bus.pix_valid), 0);
    chk({tag, " pix_sof|eol"}, int'(bus.pix_sof | bus.pix_eol), 0);
    chk({tag, " pix_x|y|data"}, int'(bus.pix_x | bus.pix_y | 10'(bus.pix_data) | 10'(bus.pix_data >> 10)), 0);
    chk({tag, " meas_width"}, int'(bus.meas_width), 0);
    chk({tag, " meas_height"}, int'(bus.meas_height), 0);
    chk({tag, " frame_cnt"}, int'(bus.frame_cnt), 0);
    chk({tag, " done|errs|locked"}, int'(bus.frame_done | bus.err_hlen | bus.err_vlen | bus.locked), 0);
  endtask

  task automatic check_frame(input string tag, input vec_t v, input int nclosed);
    chk({tag, " frame_done count"}, fd_cnt, fd_exp);
    chk({tag, " frame_cnt"}, int'(bus.frame_cnt), nclosed);
    chk({tag, " meas_width"}, int'(bus.meas_width), v.w);
    chk({tag, " meas_height"}, int'(bus.meas_height), v.h);
    chk({tag, " err_hlen"}, int'(bus.err_hlen), int'(v.eh));
    chk({tag, " err_vlen"}, int'(bus.err_vlen), int'(v.ev));
    chk({tag, " locked"}, int'(bus.locked), int'(v.lk));
    chk({tag, " valid count"}, snap_v, v.nv);
    chk({tag, " eol count"}, snap_eol, v.neol);
    chk({tag, " sof count"}, snap_sof, 1);
    chk({tag, " scoreboard bad"}, sb_bad, 0);
    chk({tag, " scoreboard pending"}, exp_q.size(), 0);
  endtask

  initial begin
    //           lines sidx slen   w   h  eh ev lk  nv  neol
    vec[0] = '{6, -1, 0,  16, 6, 0, 0, 0, 96, 6};   // first good frame, not yet locked
    vec[1] = '{6, -1, 0,  16, 6, 0, 0, 1, 96, 6};   // second good frame locks
    vec[2] = '{6, -1, 0,  16, 6, 0, 0, 1, 96, 6};
    vec[3] = '{6,  2, 10, 16, 6, 1, 0, 0, 90, 5};   // short line drops lock
    vec[4] = '{6, -1, 0,  16, 6, 0, 0, 0, 96, 6};
    vec[5] = '{6, -1, 0,  16, 6, 0, 0, 1, 96, 6};   // relock after two good frames
    vec[6] = '{9, -1, 0,  16, 9, 0, 1, 0, 96, 6};   // extra lines dropped, counted
    vec[7] = '{6,  5, 20, 20, 6, 1, 0, 0, 96, 6};   // long last line sets width
    vec[8] = '{6, -1, 0,  16, 6, 0, 0, 0, 96, 6};
    vec[9] = '{6, -1, 0,  16, 6, 0, 0, 1, 96, 6};
    nom_unlk = '{6, -1, 0, 16, 6, 0, 0, 0, 96, 6};
    nom_lk   = '{6, -1, 0, 16, 6, 0, 0, 1, 96, 6};

    bus.vid_vsync = 1'b1;
    bus.vid_hsync = 1'b0;
    bus.vid_de    = 1'b0;
    bus.vid_rgb   = '0;

    repeat (3) tick();
    chk_zero("reset");
    sys_rst = 1'b0;
    tick();

    // DE activity before any vsync must be ignored.
    for (int l = 0; l < 5; l++) send_line(l, H);
    chk("presync valid", tot_v, 0);
    chk("presync frame_cnt", int'(bus.frame_cnt), 0);
    chk("presync frame_done", fd_cnt, 0);

    for (int i = 0; i < 10; i++) begin
      vs_pulse();
      if (i > 0) begin
        fd_exp++;
        check_frame($sformatf("vec%0d", i - 1), vec[i - 1], i);
      end
      seed = 16'(i * 16'h1357);
      cap  = 1'b1;
      send_frame(vec[i]);
    end
    vs_pulse();
    fd_exp++;
    check_frame("vec9", vec[9], 10);

    // Reset in the middle of line 3 of a frame.
    seed = 16'hA5A5;
    for (int l = 0; l < 3; l++) send_line(l, H);
    for (int c = 0; c < 5; c++) begin
      drive_pix(3, c);
      tick();
    end
    cap = 1'b0;
    sys_rst = 1'b1;
    drive_pix(3, 5);
    tick();
    sys_rst = 1'b0;
    chk_zero("midreset");
    for (int c = 6; c < H; c++) begin
      drive_pix(3, c);
      tick();
    end
    bus.vid_de = 1'b0;
    repeat (4) tick();
    for (int l = 4; l < V; l++) send_line(l, H);
    vs_pulse();
    chk("midreset no frame_done", fd_cnt, fd_exp);
    chk("midreset frame_cnt", int'(bus.frame_cnt), 0);
    cap  = 1'b1;
    seed = 16'h0F0F;
    for (int l = 0; l < V; l++) send_line(l, H);

    // vs_start and de_rise together: that pixel is (0,0) of the new frame.
    seed = 16'h3C3C;
    bus.vid_vsync = 1'b0;
    drive_pix(0, 0);
    tick();
    drive_pix(0, 1);
    tick();
    chk("coinc pix_valid", int'(bus.pix_valid), 1);
    chk("coinc pix_sof", int'(bus.pix_sof), 1);
    chk("coinc pix_x", int'(bus.pix_x), 0);
    chk("coinc pix_y", int'(bus.pix_y), 0);
    chk("coinc frame_done", int'(bus.frame_done), 1);
    bus.vid_vsync = 1'b1;
    for (int c = 2; c < H; c++) begin
      drive_pix(0, c);
      tick();
    end
    bus.vid_de = 1'b0;
    repeat (4) tick();
    fd_exp++;
    check_frame("postreset", nom_unlk, 1);
    for (int l = 1; l < V; l++) send_line(l, H);
    vs_pulse();
    fd_exp++;
    check_frame("coinc", nom_lk, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
